parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial parity-frame receiver that consumes a one-bit-per-clock serial stream (the same `x` bit stream the odd/even parity FSM checks) and reassembles it into framed data words. Each frame is a start bit, DATA_W data bits (LSB first), one parity bit and a stop bit. The block reports the recovered word with parity-error and framing-error flags. It sits directly downstream of the serial parity stage and hands words to word-level logic.

## Interface
- DATA_W, 8, number of data bits per frame (2..16)
- ODD, 0, parity sense: 0 = even (data + parity bit have an even count of 1s), 1 = odd
- clk  input  1  rising-edge clock; one serial bit is sampled per edge
- rst  input  1  reset; one clock, synchronous, active-high
- x  input  1  serial line; idles high
- data_out  output  DATA_W  last received word; holds until the next frame completes
- valid  output  1  one-cycle pulse: data_out, par_err and frm_err are updated
- par_err  output  1  parity mismatch in the last frame; held with data_out
- frm_err  output  1  stop bit sampled as 0 in the last frame; held with data_out
- busy  output  1  high while a frame is in progress (any state other than IDLE)
- err_cnt  output  8  saturating count of errored frames (see Configuration)

## Operation
- FSM states: IDLE, DATA, PAR, STOP.
- IDLE: when x == 0 is sampled, clear the bit counter and the running parity, then go to DATA. When x == 1, stay in IDLE.
- DATA: shift x into the shift register at the MSB end, so the first data bit ends in bit 0. XOR x into the running parity and increment the counter. After DATA_W bits, go to PAR.
- PAR: sample x as the parity bit. Set the error when (running ^ x) != ODD. Go to STOP.
- STOP: sample x. frm_err = ~x. Register data_out, par_err and frm_err, pulse valid, and return to IDLE.
- A frame with errors is still delivered (valid = 1, data_out updated); the flags qualify it.
- A 0 sampled as the stop bit is consumed as the stop bit. It is never reinterpreted as the next start bit.
- Counter width is clog2(DATA_W + 1). It never wraps within a frame.

## Timing
- Reset values: data_out = 0, valid = 0, par_err = 0, frm_err = 0, busy = 0, err_cnt = 0, FSM = IDLE.
- Start bit is sampled at edge t.
- Data bits are sampled at edges t+1 .. t+DATA_W.
- Parity bit is sampled at edge t+DATA_W+1.
- Stop bit is sampled at edge t+DATA_W+2.
- valid is high for exactly one cycle after edge t+DATA_W+2. Latency from start bit to valid is DATA_W+2 edges.
- busy is high after edges t .. t+DATA_W+1 and low after the stop edge.
- Back-to-back frames: a start bit may be sampled at edge t+DATA_W+3, which is the same cycle valid is high. The new frame proceeds normally and valid still pulses.
- rst asserted mid-frame: the partial frame is discarded, no valid pulse is produced, and every output returns to its reset value on that edge.
- rst has priority over every other event on the same edge.

## Configuration
- PARITY_RX_ERR_CNT_EN defined: err_cnt increments by 1 on each valid pulse where par_err | frm_err. It saturates at 255 and is cleared only by rst.
- PARITY_RX_ERR_CNT_EN undefined: the counter logic is not compiled. err_cnt is tied to 8'd0 and all other behaviour is unchanged.

## Test plan
- Good frame: DATA_W=8, ODD=0. Drive x = 0, then 1,0,1,0,0,1,0,1 (0xA5, LSB first), parity 0, stop 1. Required: valid pulses 10 edges after the start edge, data_out = 0xA5, par_err = 0, frm_err = 0.
- Parity error: same frame with parity bit 1. Required: data_out = 0xA5, par_err = 1, frm_err = 0. err_cnt = 1 with the macro, 0 without.
- Framing error: frame 0x3C with correct parity 0 and stop bit 0, then x = 1. Required: data_out = 0x3C, frm_err = 1, FSM in IDLE, and no spurious second frame.
- Back-to-back: frames 0x01 (parity 1) and 0xFF (parity 0) with no idle bit between them. Required: two valid pulses 11 cycles apart, data_out = 0x01 then 0xFF, no errors.
- Reset mid-frame: assert rst for one cycle after the 4th data bit, then send a good 0x5A frame. Required: no valid pulse for the aborted frame, all outputs 0 after the rst edge, then data_out = 0x5A with no errors.
- Saturation (macro defined): send 300 frames with bad parity. Required: err_cnt = 255 and it stays there. A following good frame leaves err_cnt = 255.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//   Serial parity-frame receiver. Consumes one bit per clock from the serial
//   line and reassembles frames of the form
//     start(0), DATA_W data bits (LSB first), parity bit, stop(1)
//   into words. Each completed frame is delivered with a one-cycle valid
//   pulse, qualified by parity-error and framing-error flags. Errored frames
//   are still delivered.
//
// Parameters
//   DATA_W  data bits per frame (2..16)
//   ODD     parity sense: 0 = even, 1 = odd
//
// Ports
//   clk       in   rising-edge clock, one serial bit sampled per edge
//   rst       in   synchronous active-high reset
//   x         in   serial line, idles high
//   data_out  out  last received word, held until the next frame completes
//   valid     out  one-cycle pulse when data_out/par_err/frm_err update
//   par_err   out  parity mismatch in the last frame
//   frm_err   out  stop bit sampled as 0 in the last frame
//   busy      out  high while a frame is in progress
//   err_cnt   out  saturating count of errored frames
//
// Build option
//   PARITY_RX_ERR_CNT_EN  when defined, err_cnt counts errored frames
//                         (saturating at 255); otherwise err_cnt is tied to 0.

module parity_frame_rx #(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              run_par_q;   // XOR of data bits seen so far
    logic              perr_pend_q; // parity verdict, held until the stop bit

    logic [DATA_W-1:0] data_out_q;
    logic              valid_q;
    logic              par_err_q;
    logic              frm_err_q;
    logic              busy_q;
    logic [7:0]        err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            run_par_q   <= 1'b0;
            perr_pend_q <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!x) begin
                        cnt_q     <= '0;
                        run_par_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    // MSB-end shift: after DATA_W bits the first one sits in bit 0
                    shift_q   <= {x, shift_q[DATA_W-1:1]};
                    run_par_q <= run_par_q ^ x;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= PAR;
                    end
                end
                PAR: begin
                    perr_pend_q <= ((run_par_q ^ x) != ODD);
                    state_q     <= STOP;
                end
                STOP: begin
                    // The stop bit is always consumed here, even if it is 0
                    data_out_q <= shift_q;
                    par_err_q  <= perr_pend_q;
                    frm_err_q  <= ~x;
                    valid_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
`ifdef PARITY_RX_ERR_CNT_EN
                    if ((perr_pend_q || !x) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = busy_q;

`ifdef PARITY_RX_ERR_CNT_EN
    assign err_cnt  = err_cnt_q;
`else
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx
//   Bench for parity_frame_rx (DATA_W = 8, even parity). The driver tags each
//   serial bit with its role in the frame; a reference model derives the
//   expected outputs after every clock edge from those roles and from the
//   frame contents (parity from a count of ones).

module tb_parity_frame_rx;

    localparam int unsigned DW    = 8;
    localparam bit          ODD_P = 1'b0;

    typedef enum int {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_RST} role_e;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x   = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          par_err;
    logic          frm_err;
    logic          busy;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    parity_frame_rx #(
        .DATA_W(DW),
        .ODD   (ODD_P)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .data_out(data_out),
        .valid   (valid),
        .par_err (par_err),
        .frm_err (frm_err),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    role_e         role = R_RST;
    logic [DW-1:0] stop_data = '0;
    logic          stop_perr = 1'b0;
    logic          stop_ferr = 1'b0;

    logic [DW-1:0] held_data = '0;
    logic          held_perr = 1'b0;
    logic          held_ferr = 1'b0;
    int            model_cnt = 0;

    int cyc            = 0;
    int start_cyc      = 0;
    int dut_valid_cyc  = -1;
    int prev_valid_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model and output checks, one step per clock edge
    always @(posedge clk) begin
        #1;
        cyc++;
        case (role)
            R_RST: begin
                held_data = '0;
                held_perr = 1'b0;
                held_ferr = 1'b0;
                model_cnt = 0;
            end
            R_START: start_cyc = cyc;
            R_STOP: begin
                held_data = stop_data;
                held_perr = stop_perr;
                held_ferr = stop_ferr;
`ifdef PARITY_RX_ERR_CNT_EN
                if ((stop_perr || stop_ferr) && model_cnt < 255) model_cnt++;
`endif
            end
            default: ;
        endcase
        if (valid === 1'b1) begin
            prev_valid_cyc = dut_valid_cyc;
            dut_valid_cyc  = cyc;
        end
        check_eq("valid",    32'(valid),    32'(role == R_STOP));
        check_eq("busy",     32'(busy),     32'(role inside {R_START, R_DATA, R_PAR}));
        check_eq("data_out", 32'(data_out), 32'(held_data));
        check_eq("par_err",  32'(par_err),  32'(held_perr));
        check_eq("frm_err",  32'(frm_err),  32'(held_ferr));
        check_eq("err_cnt",  32'(err_cnt),  32'(model_cnt));
    end

    task automatic drive(input logic b, input role_e r);
        @(negedge clk);
        x    = b;
        role = r;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, R_IDLE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        x    = 1'b1;
        role = R_RST;
        @(negedge clk);
        rst  = 1'b0;
        role = R_IDLE;
    endtask

    function automatic logic good_par(input logic [DW-1:0] d);
        return logic'(($countones(d) + int'(ODD_P)) % 2);
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit);
        drive(1'b0, R_START);
        for (int i = 0; i < DW; i++) drive(d[i], R_DATA);
        drive(pbit, R_PAR);
        stop_data = d;
        stop_perr = ((($countones(d) + int'(pbit)) % 2) != int'(ODD_P));
        stop_ferr = ~sbit;
        drive(sbit, R_STOP);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          p;
        logic          s;

        @(negedge clk);
        rst  = 1'b0;
        role = R_IDLE;
        idle_bits(2);

        // Good frame 0xA5 and its latency
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        check_eq("lat_good", 32'(dut_valid_cyc - start_cyc), 32'(DW + 2));

        // Parity error
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(2);

        // Framing error; the 0 stop bit must not start another frame
        send_frame(8'h3C, 1'b0, 1'b0);
        idle_bits(4);

        // Back-to-back frames
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(1);
        check_eq("b2b_gap", 32'(dut_valid_cyc - prev_valid_cyc), 32'(DW + 3));

        // Reset after the 4th data bit, then a good frame
        drive(1'b0, R_START);
        for (int i = 0; i < 4; i++) drive(1'($urandom_range(0, 1)), R_DATA);
        do_reset();
        idle_bits(1);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        idle_bits(2);

        // Randomized frames with occasional bad parity / stop and random gaps
        for (int n = 0; n < 150; n++) begin
            d = DW'($urandom);
            p = good_par(d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s);
            idle_bits(int'($urandom_range(0, 2)));
        end

        // Error counter saturation, then a good frame must not change it
        for (int n = 0; n < 300; n++) begin
            d = DW'($urandom);
            send_frame(d, ~good_par(d), 1'b1);
        end
        send_frame(8'h96, good_par(8'h96), 1'b1);
        idle_bits(2);
`ifdef PARITY_RX_ERR_CNT_EN
        check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);
`else
        check_eq("err_cnt_sat", 32'(err_cnt), 32'd0);
`endif
        check_eq("final_data", 32'(data_out), 32'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
